seq_datapath: RTL and testbench

//  Parametrised successor to the lab datapath: register file, A/B/C registers, shifter, ALU and status

---
 rtl/seq_datapath.sv | 200 ++++++++++++++++++++
 tb/tb_seq_datapath.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_datapath.sv
// Sequenced datapath: regfile, A/B/C, shifter, ALU and N/Z/V status run as RDA-RDB-EXE-WB per command.
// Optional SEQ_DP_SAT_EN: add/sub saturate to signed max/min on overflow.
module seq_datapath #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int PCW  = 8,
  localparam int RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [RW-1:0] cmd_rn,
  input  logic [RW-1:0] cmd_rm,
  input  logic [RW-1:0] cmd_rd,
  input  logic [1:0]    cmd_shift,
  input  logic [1:0]    cmd_aluop,
  input  logic          cmd_asel,
  input  logic          cmd_bsel,
  input  logic [1:0]    cmd_vsel,
  input  logic [7:0]    cmd_imm,
  input  logic          cmd_loads,
  input  logic          cmd_wb,
  input  logic [W-1:0]  mdata,
  input  logic [PCW-1:0] pc,
  output logic [W-1:0]  dp_out,
  output logic          z_out,
  output logic          n_out,
  output logic          v_out,
  output logic          done
);

  typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EXE, S_WB} state_t;

  typedef struct packed {
    logic [RW-1:0] rn;
    logic [RW-1:0] rm;
    logic [RW-1:0] rd;
    logic [1:0]    shift;
    logic [1:0]    aluop;
    logic          asel;
    logic          bsel;
    logic [1:0]    vsel;
    logic [7:0]    imm;
    logic          loads;
    logic          wb;
  } cmd_t;

  state_t                   state_q, state_d;
  cmd_t                     cmd_q, cmd_d;
  logic                     ready_q, ready_d;
  logic                     done_q, done_d;
  logic [W-1:0]             a_q, a_d, b_q, b_d, c_q, c_d;
  logic                     z_q, z_d, n_q, n_d, v_q, v_d;
  logic [NREG-1:0][W-1:0]   regs_q, regs_d;

  logic                     accept;
  logic [W-1:0]             b_sh, alu_a, alu_b, alu_res, wb_val;
  logic                     alu_v;

  assign accept = cmd_valid && ready_q;

  // Shifter sits on the B path; the immediate bypasses it.
  always_comb begin
    b_sh = b_q;
    unique case (cmd_q.shift)
      2'b00: b_sh = b_q;
      2'b01: b_sh = {b_q[W-2:0], 1'b0};
      2'b10: b_sh = {1'b0, b_q[W-1:1]};
      2'b11: b_sh = {b_q[W-1], b_q[W-1:1]};
      default: b_sh = b_q;
    endcase
  end

  always_comb begin
    alu_a   = cmd_q.asel ? '0 : a_q;
    alu_b   = cmd_q.bsel ? W'(cmd_q.imm[4:0]) : b_sh;
    alu_res = '0;
    alu_v   = 1'b0;
    unique case (cmd_q.aluop)
      2'b00: begin
        alu_res = alu_a + alu_b;
        alu_v   = (alu_a[W-1] == alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
      end
      2'b01: begin
        alu_res = alu_a - alu_b;
        alu_v   = (alu_a[W-1] != alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
      end
      2'b10: alu_res = alu_a & alu_b;
      2'b11: alu_res = ~alu_b;
      default: alu_res = '0;
    endcase
`ifdef SEQ_DP_SAT_EN
    // Overflow direction always follows A's sign for both add and subtract.
    if (alu_v)
      alu_res = alu_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
  end

  always_comb begin
    wb_val = c_q;
    unique case (cmd_q.vsel)
      2'b00: wb_val = mdata;
      2'b01: wb_val = W'($signed(cmd_q.imm));
      2'b10: wb_val = W'(pc);
      2'b11: wb_val = c_q;
      default: wb_val = c_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    regs_d  = regs_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) begin
        cmd_d.rn    = cmd_rn;
        cmd_d.rm    = cmd_rm;
        cmd_d.rd    = cmd_rd;
        cmd_d.shift = cmd_shift;
        cmd_d.aluop = cmd_aluop;
        cmd_d.asel  = cmd_asel;
        cmd_d.bsel  = cmd_bsel;
        cmd_d.vsel  = cmd_vsel;
        cmd_d.imm   = cmd_imm;
        cmd_d.loads = cmd_loads;
        cmd_d.wb    = cmd_wb;
        // Only a C writeback needs the execute pipeline.
        state_d     = (cmd_vsel == 2'b11) ? S_RDA : S_WB;
      end
      S_RDA: begin
        a_d     = regs_q[cmd_q.rn];
        state_d = S_RDB;
      end
      S_RDB: begin
        b_d     = regs_q[cmd_q.rm];
        state_d = S_EXE;
      end
      S_EXE: begin
        c_d = alu_res;
        if (cmd_q.loads) begin
          z_d = (alu_res == '0);
          n_d = alu_res[W-1];
          v_d = alu_v;
        end
        state_d = S_WB;
      end
      S_WB: begin
        if (cmd_q.wb) regs_d[cmd_q.rd] = wb_val;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
      regs_q  <= regs_d;
    end
  end

  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign dp_out    = c_q;
  assign z_out     = z_q;
  assign n_out     = n_q;
  assign v_out     = v_q;

endmodule

// File: tb/tb_seq_datapath.sv
// Directed bench for seq_datapath (W=16, NREG=8, PCW=8); expectations are hand-computed.
module tb_seq_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_rn = '0, cmd_rm = '0, cmd_rd = '0;
  logic [1:0]  cmd_shift = '0, cmd_aluop = '0, cmd_vsel = '0;
  logic        cmd_asel = 1'b0, cmd_bsel = 1'b0, cmd_loads = 1'b0, cmd_wb = 1'b0;
  logic [7:0]  cmd_imm = '0;
  logic [15:0] mdata = '0;
  logic [7:0]  pc = '0;
  logic [15:0] dp_out;
  logic        z_out, n_out, v_out, done;

  int n_asrt = 0;
  int n_fail = 0;

  seq_datapath #(.W(16), .NREG(8), .PCW(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_rd(cmd_rd), .cmd_shift(cmd_shift),
    .cmd_aluop(cmd_aluop), .cmd_asel(cmd_asel), .cmd_bsel(cmd_bsel), .cmd_vsel(cmd_vsel),
    .cmd_imm(cmd_imm), .cmd_loads(cmd_loads), .cmd_wb(cmd_wb), .mdata(mdata), .pc(pc),
    .dp_out(dp_out), .z_out(z_out), .n_out(n_out), .v_out(v_out), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call just after a negedge; returns just after the negedge on which done is seen.
  task automatic issue(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                       input logic [1:0] shift, input logic [1:0] aluop,
                       input logic asel, input logic bsel, input logic [1:0] vsel,
                       input logic [7:0] imm, input logic loads, input logic wb,
                       input logic [15:0] md, input logic [7:0] pcv, input logic hold,
                       output int lat, output int waited);
    cmd_rn = rn; cmd_rm = rm; cmd_rd = rd; cmd_shift = shift; cmd_aluop = aluop;
    cmd_asel = asel; cmd_bsel = bsel; cmd_vsel = vsel; cmd_imm = imm;
    cmd_loads = loads; cmd_wb = wb; mdata = md; pc = pcv; cmd_valid = 1'b1;
    waited = 0;
    lat = -1;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) cmd_valid = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wr_imm(input logic [2:0] rd, input logic [7:0] imm);
    int lat, wt;
    issue(3'd0, 3'd0, rd, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, imm, 1'b0, 1'b1, 16'h0, 8'h0, 1'b0, lat, wt);
    chk("lat_imm", lat, 2);
  endtask

  task automatic wr_md(input logic [2:0] rd, input logic [15:0] md);
    int lat, wt;
    issue(3'd0, 3'd0, rd, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h0, 1'b0, 1'b1, md, 8'h0, 1'b0, lat, wt);
    chk("lat_mdata", lat, 2);
  endtask

  task automatic alu(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                     input logic [1:0] shift, input logic [1:0] aluop, input logic bsel,
                     input logic [7:0] imm, input logic loads, input logic wb);
    int lat, wt;
    issue(rn, rm, rd, shift, aluop, 1'b0, bsel, 2'b11, imm, loads, wb, 16'h0, 8'h0, 1'b0, lat, wt);
    chk("lat_alu", lat, 5);
  endtask

  // C = 0 + R[r], no flag update, no writeback.
  task automatic rd_reg(input string tag, input logic [2:0] r, input logic [15:0] exp);
    int lat, wt;
    issue(3'd0, r, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, lat, wt);
    chk("lat_read", lat, 5);
    chk(tag, dp_out, exp);
  endtask

  initial begin
    int lat, wt, dones;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_dp", dp_out, 16'h0);
    chk("rst_flags", {z_out, n_out, v_out}, 3'b000);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during EXE of a command targeting R1 (C would be 5)
    cmd_rn = 3'd0; cmd_rm = 3'd0; cmd_rd = 3'd1; cmd_shift = 2'b00; cmd_aluop = 2'b00;
    cmd_asel = 1'b1; cmd_bsel = 1'b1; cmd_imm = 8'h05; cmd_vsel = 2'b11;
    cmd_loads = 1'b1; cmd_wb = 1'b1; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("busy_ready", cmd_ready, 0);
    rst_n = 1'b0;
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_done", dones, 0);
    chk("abort_dp", dp_out, 16'h0);
    chk("abort_flags", {z_out, n_out, v_out}, 3'b000);
    chk("abort_ready", cmd_ready, 1);
    rd_reg("abort_r1", 3'd1, 16'h0000);

    // 5 - (3<<1) = -1
    wr_imm(3'd0, 8'd5);
    wr_imm(3'd1, 8'd3);
    alu(3'd0, 3'd1, 3'd3, 2'b01, 2'b01, 1'b0, 8'h0, 1'b1, 1'b1);
    chk("sub_dp", dp_out, 16'hFFFF);
    chk("sub_flags", {z_out, n_out, v_out}, 3'b010);
    @(negedge clk);
    chk("done_pulse_width", done, 0);

    // Immediate-only write leaves C and flags alone
    wr_imm(3'd2, 8'hF6);
    chk("imm_dp_kept", dp_out, 16'hFFFF);
    chk("imm_flags_kept", {z_out, n_out, v_out}, 3'b010);
    rd_reg("sext_r2", 3'd2, 16'hFFF6);
    rd_reg("sub_r3", 3'd3, 16'hFFFF);
    chk("read_flags_kept", {z_out, n_out, v_out}, 3'b010);

    // Signed add overflow
    wr_md(3'd0, 16'h7FFF);
    wr_imm(3'd1, 8'd1);
    alu(3'd0, 3'd1, 3'd4, 2'b00, 2'b00, 1'b0, 8'h0, 1'b1, 1'b1);
`ifdef SEQ_DP_SAT_EN
    chk("addovf_dp", dp_out, 16'h7FFF);
    chk("addovf_flags", {z_out, n_out, v_out}, 3'b001);
    rd_reg("addovf_r4", 3'd4, 16'h7FFF);
`else
    chk("addovf_dp", dp_out, 16'h8000);
    chk("addovf_flags", {z_out, n_out, v_out}, 3'b011);
    rd_reg("addovf_r4", 3'd4, 16'h8000);
`endif

    // Zero result, then loads=0 keeps flags
    wr_md(3'd0, 16'h00F0);
    wr_md(3'd1, 16'h00F0);
    alu(3'd0, 3'd1, 3'd4, 2'b00, 2'b01, 1'b0, 8'h0, 1'b1, 1'b1);
    chk("zero_dp", dp_out, 16'h0000);
    chk("zero_flags", {z_out, n_out, v_out}, 3'b100);
    wr_imm(3'd1, 8'd1);
    alu(3'd0, 3'd1, 3'd4, 2'b00, 2'b01, 1'b0, 8'h0, 1'b0, 1'b1);
    chk("noload_dp", dp_out, 16'h00EF);
    chk("noload_flags", {z_out, n_out, v_out}, 3'b100);

    // Shifts, AND, NOT, immediate B, subtract overflow
    wr_md(3'd5, 16'h8001);
    alu(3'd5, 3'd5, 3'd6, 2'b11, 2'b11, 1'b0, 8'h0, 1'b1, 1'b1);
    chk("asr_not_dp", dp_out, 16'h3FFF);
    chk("asr_not_flags", {z_out, n_out, v_out}, 3'b000);
    alu(3'd5, 3'd5, 3'd6, 2'b10, 2'b10, 1'b0, 8'h0, 1'b1, 1'b1);
    chk("lsr_and_dp", dp_out, 16'h0000);
    chk("lsr_and_flags", {z_out, n_out, v_out}, 3'b100);
    alu(3'd5, 3'd0, 3'd6, 2'b00, 2'b00, 1'b1, 8'hFF, 1'b1, 1'b1);
    chk("bsel_dp", dp_out, 16'h8020);
    chk("bsel_flags", {z_out, n_out, v_out}, 3'b010);
    alu(3'd5, 3'd0, 3'd6, 2'b00, 2'b01, 1'b0, 8'h0, 1'b1, 1'b1);
`ifdef SEQ_DP_SAT_EN
    chk("subovf_dp", dp_out, 16'h8000);
    chk("subovf_flags", {z_out, n_out, v_out}, 3'b011);
`else
    chk("subovf_dp", dp_out, 16'h7F11);
    chk("subovf_flags", {z_out, n_out, v_out}, 3'b001);
`endif

    // PC writeback zero-extends
    issue(3'd0, 3'd0, 3'd6, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 8'h0, 1'b0, 1'b1, 16'h0, 8'hA5, 1'b0, lat, wt);
    chk("lat_pc", lat, 2);
    rd_reg("pc_r6", 3'd6, 16'h00A5);

    // wb=0 still completes but leaves the regfile alone
    alu(3'd5, 3'd5, 3'd6, 2'b00, 2'b00, 1'b0, 8'h0, 1'b0, 1'b0);
    chk("nowb_dp", dp_out, 16'h0002);
    issue(3'd0, 3'd0, 3'd6, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h0, 1'b0, 1'b0, 16'h1234, 8'h0, 1'b0, lat, wt);
    chk("lat_nowb", lat, 2);
    rd_reg("nowb_r6", 3'd6, 16'h00A5);

    // rd == rn == rm reads the pre-write value
    alu(3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 8'h0, 1'b0, 1'b1);
    rd_reg("self_r0", 3'd0, 16'h01E0);

    // Back-to-back with cmd_valid held high
    issue(3'd0, 3'd0, 3'd7, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 8'h11, 1'b0, 1'b1, 16'h0, 8'h0, 1'b1, lat, wt);
    chk("b2b_lat1", lat, 2);
    chk("b2b_ready_in_done", cmd_ready, 1);
    issue(3'd0, 3'd7, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, lat, wt);
    chk("b2b_wait", wt, 0);
    chk("b2b_lat2", lat, 5);
    chk("b2b_dp", dp_out, 16'h0011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
